// File: rtl/cell_test_pkg.sv
// cell_test_pkg -- shared types and helpers for the cell test sequencer.
//   state_e      : sequencer FSM states
//   nv_of()      : number of stimulus vectors for a given input width
//   settle_cnt_w(): width of the settle-cycle counter
package cell_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic int unsigned nv_of(input int unsigned in_w);
    return 32'd1 << in_w;
  endfunction

  // Counter only needs to reach SETTLE-1; keep at least one bit.
  function automatic int unsigned settle_cnt_w(input int unsigned settle);
    return (settle <= 1) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/cell_test_chk.sv
// cell_test_chk -- per-channel checker for one cell under test.
// Compares the CUT output against the latched truth-table bit for the
// current vector, keeps a saturating mismatch count and the pass flag.
// Optional first-fail log when CELLTEST_FAIL_LOG_EN is defined.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   clr_i           : clear count/pass (run start)
//   cap_i           : capture strobe for the current vector
//   last_i          : current vector is the final one
//   vec_i           : current vector index
//   tt_i            : this channel's expected truth table
//   cut_out_i       : CUT output
//   err_cnt_o       : saturating mismatch count
//   pass_o          : run passed (valid from the done cycle)
//   first_fail_o    : vector of the first mismatch (macro only)
//   fail_seen_o     : a mismatch has been recorded (macro only)
module cell_test_chk
  import cell_test_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned ERR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr_i,
  input  logic                      cap_i,
  input  logic                      last_i,
  input  logic [IN_W-1:0]           vec_i,
  input  logic [nv_of(IN_W)-1:0]    tt_i,
  input  logic                      cut_out_i,
  output logic [ERR_W-1:0]          err_cnt_o,
  output logic                      pass_o
`ifdef CELLTEST_FAIL_LOG_EN
  ,
  output logic [IN_W-1:0]           first_fail_o,
  output logic                      fail_seen_o
`endif
);

  logic             mismatch;
  logic [ERR_W-1:0] err_cnt_d, err_cnt_q;
  logic             pass_d, pass_q;

  assign mismatch = cut_out_i != tt_i[vec_i];

  // Pass is resolved on the final capture so it appears with done_o.
  always_comb begin
    err_cnt_d = err_cnt_q;
    pass_d    = pass_q;
    if (clr_i) begin
      err_cnt_d = '0;
      pass_d    = 1'b0;
    end else if (cap_i) begin
      if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
      if (last_i) pass_d = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      err_cnt_q <= err_cnt_d;
      pass_q    <= pass_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign pass_o    = pass_q;

`ifdef CELLTEST_FAIL_LOG_EN
  logic [IN_W-1:0] first_fail_d, first_fail_q;
  logic            fail_seen_d, fail_seen_q;

  always_comb begin
    first_fail_d = first_fail_q;
    fail_seen_d  = fail_seen_q;
    if (clr_i) begin
      first_fail_d = '0;
      fail_seen_d  = 1'b0;
    end else if (cap_i && mismatch && !fail_seen_q) begin
      first_fail_d = vec_i;
      fail_seen_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      first_fail_q <= '0;
      fail_seen_q  <= 1'b0;
    end else begin
      first_fail_q <= first_fail_d;
      fail_seen_q  <= fail_seen_d;
    end
  end

  assign first_fail_o = first_fail_q;
  assign fail_seen_o  = fail_seen_q;
`endif

endmodule

// File: rtl/cell_test_sequencer.sv
// cell_test_sequencer -- exhaustively drives all 2^IN_W vectors to NUM_CH
// cells in parallel, waits SETTLE cycles per vector, compares each CUT
// output against a latched truth table and reports pass/mismatch counts.
// Optional first-fail log: define CELLTEST_FAIL_LOG_EN.
// Ports:
//   wb_clk_i, wb_rst_n_i : clock, synchronous active-low reset
//   start_i, abort_i     : run request / run abort (abort wins)
//   tt_i                 : expected truth tables, bit [ch*NV+v]
//   cut_in_o             : shared stimulus vector
//   cut_out_i            : CUT outputs
//   busy_o, done_o       : run in progress / 1-cycle completion pulse
//   pass_o, err_cnt_o    : per-channel pass flags and mismatch counts
//   first_fail_o, fail_seen_o : per-channel first-fail log (macro only)
module cell_test_sequencer
  import cell_test_pkg::*;
#(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned IN_W   = 4,
  parameter int unsigned SETTLE = 4,
  parameter int unsigned ERR_W  = 4
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          start_i,
  input  logic                          abort_i,
  input  logic [NUM_CH*nv_of(IN_W)-1:0] tt_i,
  output logic [IN_W-1:0]               cut_in_o,
  input  logic [NUM_CH-1:0]             cut_out_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [NUM_CH-1:0]             pass_o,
  output logic [NUM_CH*ERR_W-1:0]       err_cnt_o
`ifdef CELLTEST_FAIL_LOG_EN
  ,
  output logic [NUM_CH*IN_W-1:0]        first_fail_o,
  output logic [NUM_CH-1:0]             fail_seen_o
`endif
);

  localparam int unsigned NV = nv_of(IN_W);
  localparam int unsigned CW = settle_cnt_w(SETTLE);

  state_e               state_d, state_q;
  logic [IN_W-1:0]      vec_d, vec_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic [NUM_CH*NV-1:0] tt_d, tt_q;
  logic [IN_W-1:0]      cut_in_d, cut_in_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic                 start_ok;
  logic                 cap;
  logic                 last_vec;

  assign last_vec = (vec_q == '1);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    tt_d     = tt_q;
    start_ok = 1'b0;
    cap      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          tt_d     = tt_i;
          vec_d    = '0;
          cnt_d    = '0;
          start_ok = 1'b1;
          state_d  = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        cnt_d   = '0;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_CAPTURE: begin
        cap = 1'b1;
        if (last_vec) begin
          vec_d   = '0;
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_DRIVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides everything, including a capture in progress.
    if ((state_q != ST_IDLE) && abort_i) begin
      state_d = ST_IDLE;
      vec_d   = '0;
      cnt_d   = '0;
      cap     = 1'b0;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    busy_d   = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) ||
               (state_d == ST_CAPTURE);
    done_d   = (state_d == ST_DONE);
    cut_in_d = busy_d ? vec_d : '0;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q  <= ST_IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      tt_q     <= '0;
      cut_in_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      tt_q     <= tt_d;
      cut_in_q <= cut_in_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cut_in_o = cut_in_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    cell_test_chk #(
      .IN_W  (IN_W),
      .ERR_W (ERR_W)
    ) u_chk (
      .clk          (wb_clk_i),
      .rst_n        (wb_rst_n_i),
      .clr_i        (start_ok),
      .cap_i        (cap),
      .last_i       (last_vec),
      .vec_i        (vec_q),
      .tt_i         (tt_q[ch*NV +: NV]),
      .cut_out_i    (cut_out_i[ch]),
      .err_cnt_o    (err_cnt_o[ch*ERR_W +: ERR_W]),
      .pass_o       (pass_o[ch])
`ifdef CELLTEST_FAIL_LOG_EN
      ,
      .first_fail_o (first_fail_o[ch*IN_W +: IN_W]),
      .fail_seen_o  (fail_seen_o[ch])
`endif
    );
  end

endmodule
